fact_host: RTL

- Bus-initiator front end for the factorial peripheral's 2-bit-address register interface.
  - Address 00: write n (4 bits).
  - Address 01: write go (wd[0]).
  - Address 10: read done flag (rd[0]).
  - Address 11: read 32-bit result.
- On a single `start` pulse it performs the whole transaction sequence: write n, pulse go, poll done, read result. It then returns the result with a one-cycle `done` strobe.
- Sits between a controller or testbench and the peripheral's `we`/`a`/`wd`/`rd` pins.

---
 rtl/fact_host_if.sv | 10 +
 rtl/fact_host.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fact_host_if.sv
// Peripheral register bus between fact_host (master) and the factorial peripheral (slave).
interface fact_host_if;
  logic        we;
  logic [1:0]  a;
  logic [3:0]  wd;
  logic [31:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_host.sv
// Bus initiator for the factorial peripheral: write n, pulse go, poll done, read result.
// Optional poll timeout compiled in with `define FACT_HOST_TIMEOUT_EN.
module fact_host #(
  parameter int unsigned GO_SETTLE = 2,
  parameter int unsigned POLL_MAX  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n_in,
  fact_host_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  if (GO_SETTLE < 1 || GO_SETTLE > 15) begin : g_bad_settle
    $error("fact_host: GO_SETTLE out of range 1..15");
  end
  if (POLL_MAX < 2 || POLL_MAX > 65535) begin : g_bad_poll
    $error("fact_host: POLL_MAX out of range 2..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO,
    WR_GO_CLR,
    SETTLE,
    POLL,
    READ,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(GO_SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] n_q;
  logic [3:0] settle_cnt;
  logic       timeout_hit;
  logic       accept;

  assign accept = (state == IDLE) && start;

`ifdef FACT_HOST_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  logic [15:0] poll_cnt;

  // Held at zero outside POLL, so it is already clear on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (state != POLL) begin
      poll_cnt <= '0;
    end else if (!bus.rd[0]) begin
      poll_cnt <= poll_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == POLL) && !bus.rd[0] && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.we    = 1'b0;
    bus.a     = 2'b00;
    bus.wd    = 4'h0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = WR_N;
      end
      WR_N: begin
        bus.we    = 1'b1;
        bus.a     = 2'b00;
        bus.wd    = n_q;
        state_nxt = WR_GO;
      end
      WR_GO: begin
        bus.we    = 1'b1;
        bus.a     = 2'b01;
        bus.wd    = 4'b0001;
        state_nxt = WR_GO_CLR;
      end
      WR_GO_CLR: begin
        bus.we    = 1'b1;
        bus.a     = 2'b01;
        bus.wd    = 4'b0000;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        // rd is deliberately not looked at: the done flag may still be stale here.
        bus.a = 2'b10;
        if (settle_cnt == 4'd0) state_nxt = POLL;
      end
      POLL: begin
        bus.a = 2'b10;
        if (bus.rd[0]) begin
          state_nxt = READ;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        bus.a     = 2'b11;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      settle_cnt <= '0;
      result     <= '0;
    end else begin
      if (accept) n_q <= n_in;
      if (state == WR_GO_CLR) begin
        settle_cnt <= SETTLE_LAST;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (state == READ) result <= bus.rd;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
